// File: rtl/uart_rx_deframer.sv
// Frame parser behind a UART receiver: SOF, LEN, payload, XOR checksum; payload released on a valid/ready stream.
// Optional inter-byte timeout enabled by defining UART_RX_DEFRAMER_TIMEOUT_EN.
module uart_rx_deframer #(
   parameter logic [7:0] SOF_BYTE     = 8'hA5,
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_CLKS = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_d_i,
   input  logic       rx_done_i,
   output logic [7:0] m_data_o,
   output logic       m_valid_o,
   output logic       m_last_o,
   input  logic       m_ready_i,
   output logic       frame_ok_o,
   output logic       frame_err_o,
   output logic [1:0] err_code_o,
   output logic [7:0] drop_cnt_o,
   output logic       busy_o
);

   localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   if (MAX_LEN < 2 || MAX_LEN > 256 || TIMEOUT_CLKS < 1) begin : g_bad_param
      $error("uart_rx_deframer: parameter out of range");
   end

   typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_len;
   logic [7:0]       r_csum;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [7:0]       r_buf [MAX_LEN];
   logic             r_ok;
   logic             r_err;
   logic [1:0]       r_code;
   logic [7:0]       r_drop;

   logic       w_ok_set;
   logic       w_err_set;
   logic [1:0] w_code_nxt;
   logic [8:0] w_len_m1;
   logic       w_len_ok;
   logic       w_wr_last;
   logic       w_rd_last;
   logic       w_xfer;
   logic       w_active;
   logic       w_tmo_exp;

   assign w_len_m1  = {1'b0, r_len} - 9'd1;
   assign w_len_ok  = (rx_d_i != 8'd0) && ({1'b0, rx_d_i} <= 9'(MAX_LEN));
   assign w_wr_last = ({{(9-PTR_W){1'b0}}, r_wr_ptr} == w_len_m1);
   assign w_rd_last = ({{(9-PTR_W){1'b0}}, r_rd_ptr} == w_len_m1);
   assign w_active  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
   assign w_xfer    = m_valid_o & m_ready_i;

`ifdef UART_RX_DEFRAMER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
   logic [TMO_W-1:0] r_tmo;

   // Reloads on every received byte, so a strobe on the expiry cycle always wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo <= '0;
      end else if (rx_done_i) begin
         r_tmo <= TMO_W'(TIMEOUT_CLKS);
      end else if (w_active && r_tmo != '0) begin
         r_tmo <= r_tmo - TMO_W'(1);
      end
   end

   assign w_tmo_exp = w_active && !rx_done_i && (r_tmo == TMO_W'(1));
`else
   assign w_tmo_exp = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ok_set    = 1'b0;
      w_err_set   = 1'b0;
      w_code_nxt  = r_code;
      unique case (r_state)
         S_HUNT: begin
            if (rx_done_i && rx_d_i == SOF_BYTE) w_state_nxt = S_LEN;
         end
         S_LEN: begin
            if (rx_done_i) begin
               if (w_len_ok) begin
                  w_state_nxt = S_PAYLOAD;
               end else begin
                  w_state_nxt = S_HUNT;
                  w_err_set   = 1'b1;
                  w_code_nxt  = 2'd1;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_done_i && w_wr_last) w_state_nxt = S_CSUM;
         end
         S_CSUM: begin
            if (rx_done_i) begin
               if (rx_d_i == r_csum) begin
                  w_state_nxt = S_DRAIN;
                  w_ok_set    = 1'b1;
               end else begin
                  w_state_nxt = S_HUNT;
                  w_err_set   = 1'b1;
                  w_code_nxt  = 2'd2;
               end
            end
         end
         S_DRAIN: begin
            if (w_xfer && w_rd_last) w_state_nxt = S_HUNT;
         end
         default: w_state_nxt = S_HUNT;
      endcase
      if (w_tmo_exp) begin
         w_state_nxt = S_HUNT;
         w_err_set   = 1'b1;
         w_code_nxt  = 2'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ok   <= 1'b0;
         r_err  <= 1'b0;
         r_code <= 2'd0;
         r_drop <= 8'd0;
      end else begin
         r_ok   <= w_ok_set;
         r_err  <= w_err_set;
         r_code <= w_code_nxt;
         // The receiver cannot stall, so bytes landing while draining are lost.
         if (r_state == S_DRAIN && rx_done_i && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
   end

   // Frame datapath needs no reset: every field is initialised by the SOF/LEN bytes.
   always_ff @(posedge clk) begin
      if (rx_done_i) begin
         unique case (r_state)
            S_HUNT: begin
               r_wr_ptr <= '0;
               r_csum   <= 8'd0;
            end
            S_LEN: begin
               r_len  <= rx_d_i;
               r_csum <= rx_d_i;
            end
            S_PAYLOAD: begin
               r_buf[r_wr_ptr] <= rx_d_i;
               r_csum          <= r_csum ^ rx_d_i;
               if (!w_wr_last) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            S_CSUM:  r_rd_ptr <= '0;
            default: ;
         endcase
      end
      if (w_xfer && !w_rd_last) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
   end

   assign m_valid_o   = (r_state == S_DRAIN);
   assign m_data_o    = m_valid_o ? r_buf[r_rd_ptr] : 8'd0;
   assign m_last_o    = m_valid_o && w_rd_last;
   assign frame_ok_o  = r_ok;
   assign frame_err_o = r_err;
   assign err_code_o  = r_code;
   assign drop_cnt_o  = r_drop;
   assign busy_o      = (r_state != S_HUNT);

endmodule
